sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, giving the number of clocks each 16-bit SRAM access is held.
REQ-002 SHALL have parameter BASE_ADDR, default 1024, giving the CPU byte address mapped to SRAM word 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1 bit: MEM-stage write request, level-held until ready.
REQ-006 SHALL have port rd_en, input, 1 bit: MEM-stage read request, level-held until ready.
REQ-007 SHALL have port address, input, 32 bits: CPU byte address.
REQ-008 SHALL have port write_data, input, 32 bits: store data.
REQ-009 SHALL have port read_data, output, 32 bits: load data, valid while ready=1 in DONE.
REQ-010 SHALL have port ready, output, 1 bit: 0 means freeze the pipeline.
REQ-011 SHALL have port sram_addr, output, 18 bits: SRAM halfword address.
REQ-012 SHALL have port sram_dq_out, output, 16 bits: SRAM write data.
REQ-013 SHALL have port sram_dq_oe, output, 1 bit: drive enable for sram_dq_out.
REQ-014 SHALL have port sram_dq_in, input, 16 bits: SRAM read data.
REQ-015 SHALL have port sram_we_n, output, 1 bit: active-low SRAM write strobe.

Function
REQ-016 SHALL implement the FSM states IDLE, LOW, HIGH and DONE.
REQ-017 SHALL go IDLE->LOW when wr_en|rd_en, LOW->HIGH after WAIT_CYCLES clocks, HIGH->DONE after WAIT_CYCLES clocks, and DONE->IDLE unconditionally.
REQ-018 SHALL drive ready=1 only in IDLE with no request, or in DONE; ready SHALL be 0 combinationally in IDLE with a request, and in LOW and HIGH.
REQ-019 SHALL hold ready low for exactly 2*WAIT_CYCLES+1 cycles per access, ending with a single ready=1 cycle in DONE.
REQ-020 SHALL compute the word address as word = (address - BASE_ADDR)[18:2], using modulo-2^32 subtraction.
REQ-021 SHALL drive sram_addr={word,1'b0} in LOW and {word,1'b1} in HIGH.
REQ-022 SHALL give writes priority when wr_en and rd_en are both 1, with the mode latched on IDLE->LOW.
REQ-023 SHALL, on a write, assert sram_we_n=0 and sram_dq_oe=1 throughout LOW and HIGH, with sram_dq_out=write_data[15:0] in LOW and write_data[31:16] in HIGH.
REQ-024 SHALL, on a read, keep sram_we_n=1 and sram_dq_oe=0, capture sram_dq_in into the low half on the last LOW cycle and the high half on the last HIGH cycle, and hold read_data until the next read completes.
REQ-025 SHALL ignore changes to the request inputs, address or write_data while in LOW, HIGH or DONE.
REQ-026 SHALL, in DONE, sample no new request; a request still asserted in the following IDLE SHALL start a new access.
REQ-027 SHALL, when WAIT_CYCLES=1, spend one cycle each in LOW and HIGH.

Reset
REQ-028 SHALL, on rst (asynchronous, any state including mid-access), force state=IDLE, wait counter=0, read_data=0, sram_we_n=1, sram_dq_oe=0 and sram_addr=0.
REQ-029 SHALL hold ready=1 while rst is high.

Structure
REQ-030 SHALL take the state encoding, BASE_ADDR and the default WAIT_CYCLES from a shared package (sram_pkg).
REQ-031 SHALL hold read_data in two 16-bit instances of the existing Register module, with freeze driven low except on the capture cycle.
REQ-032 SHALL keep the FSM and the wait counter in the top-level module, with no other sub-module.

Verification
REQ-033 Reset: rst pulse mid-HIGH -> next sample shows IDLE, ready=1, sram_we_n=1, sram_dq_oe=0.
REQ-034 Write: wr_en, address=1024, write_data=0xDEADBEEF -> sram_addr=0 with dq=0xBEEF for 2 cycles, then sram_addr=1 with dq=0xDEAD for 2 cycles; ready low 5 cycles, then high 1 cycle.
REQ-035 Read: rd_en, address=1032, SRAM model returns 0x5678 at halfword 4 and 0x1234 at halfword 5 -> sram_addr 4 then 5; read_data=0x12345678 in DONE.
REQ-036 Conflict: wr_en=rd_en=1 -> a write cycle is performed; read_data unchanged.
REQ-037 Back-to-back: request held through DONE -> second access begins the cycle after DONE; ready pattern 0x5,1,0x5,1 (five lows, one high, repeated).
REQ-038 Wrap: address=1020 -> sram_addr={0x1FFFF,0} and then {0x1FFFF,1}.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM controller: state encoding and default
// address map / timing constants.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] SRAM_BASE_ADDR   = 32'd1024;
  localparam int          SRAM_WAIT_CYCLES = 2;

endpackage

// File: rtl/sram_controller_register.sv
// Storage register with asynchronous reset; freeze acts as the load strobe,
// so q only changes on the cycle freeze is driven high.
module register #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (freeze) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Splits a 32-bit CPU access into two 16-bit SRAM accesses (low half, then
// high half), each held for WAIT_CYCLES clocks, stalling the pipeline meanwhile.
module sram_controller
  import sram_pkg::*;
#(
  parameter int          WAIT_CYCLES = SRAM_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output state_t      debug_state
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  // Handshake: a request (wr_en|rd_en) is level-held by the CPU; it is taken
  // only in IDLE, and the CPU may drop or change it once ready=1 in DONE.
  state_t        state, next_state;
  logic [CW-1:0] cnt, cnt_next;
  logic          mode_wr;
  logic [16:0]   word_q;
  logic [16:0]   word_next;
  logic [31:0]   wdata_q;
  logic          req, start, last, cap_lo, cap_hi;

  assign req       = wr_en | rd_en;
  assign start     = (state == IDLE) && req;
  assign last      = (cnt == LAST);
  assign word_next = 17'((address - BASE_ADDR) >> 2);
  assign cap_lo    = (state == LOW)  && last && !mode_wr;
  assign cap_hi    = (state == HIGH) && last && !mode_wr;

  assign debug_state = state;
  assign ready       = rst || (state == DONE) || ((state == IDLE) && !req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mode_wr <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      // Writes win when both requests are raised together.
      if (start) begin
        mode_wr <= wr_en;
        word_q  <= word_next;
        wdata_q <= write_data;
      end
    end
  end

  always_comb begin
    next_state  = state;
    cnt_next    = cnt;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (req) next_state = LOW;
      end
      LOW: begin
        sram_addr = {word_q, 1'b0};
        if (mode_wr) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[15:0];
        end
        if (last) begin
          next_state = HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HIGH: begin
        sram_addr = {word_q, 1'b1};
        if (mode_wr) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[31:16];
        end
        if (last) begin
          next_state = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        cnt_next   = '0;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  register #(.W(16)) u_rd_lo (
    .clk    (clk),
    .rst    (rst),
    .freeze (cap_lo),
    .d      (sram_dq_in),
    .q      (read_data[15:0])
  );

  register #(.W(16)) u_rd_hi (
    .clk    (clk),
    .rst    (rst),
    .freeze (cap_hi),
    .d      (sram_dq_in),
    .q      (read_data[31:16])
  );

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: an external SRAM device model plus
// a word-level reference memory and expected-read queue.
module tb_sram_controller;
  import sram_pkg::*;

  localparam int W = 2;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
  state_t      debug_state;

  int total;
  int bad;

  logic [15:0] sram_mem [0:262143];
  logic [15:0] ref_mem [int];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n),
    .debug_state (debug_state)
  );

  // Clock and external SRAM device
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
  end
  assign sram_dq_in = sram_mem[sram_addr];

  // One full CPU access, checked cycle by cycle against plain address arithmetic.
  task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wd, input logic hold);
    logic [16:0] w;
    logic [17:0] exp_addr;
    logic [15:0] exp_dq;
    int k0;
    int k1;
    w  = 17'((addr - 32'd1024) >> 2);
    k0 = int'({14'd0, w, 1'b0});
    k1 = int'({14'd0, w, 1'b1});
    if (wr) begin
      ref_mem[k0] = wd[15:0];
      ref_mem[k1] = wd[31:16];
    end else begin
      exp_q.push_back({ref_mem[k1], ref_mem[k0]});
    end
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = addr; write_data = wd;
    #1;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_on_request: got %b want 0", ready);
    end
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      exp_addr = {w, (i >= W) ? 1'b1 : 1'b0};
      exp_dq   = (i >= W) ? wd[31:16] : wd[15:0];
      total++;
      if (sram_addr !== exp_addr || ready !== 1'b0 || sram_we_n !== !wr ||
          sram_dq_oe !== wr || (wr && sram_dq_out !== exp_dq)) begin
        bad++;
        $display("FAIL access_cycle%0d: addr=%h rdy=%b we_n=%b oe=%b dq=%h want addr=%h rdy=0 we_n=%b oe=%b dq=%h",
                 i, sram_addr, ready, sram_we_n, sram_dq_oe, sram_dq_out,
                 exp_addr, !wr, wr, exp_dq);
      end
      wr_en = 1'($urandom); rd_en = 1'($urandom);
      address = $urandom; write_data = $urandom;
    end
    @(negedge clk);
    if (!wr) last_rd = exp_q.pop_front();
    total++;
    if (ready !== 1'b1 || debug_state !== DONE || read_data !== last_rd) begin
      bad++;
      $display("FAIL access_done: rdy=%b state=%0d rd=%h want rdy=1 state=%0d rd=%h",
               ready, debug_state, read_data, DONE, last_rd);
    end
    if (hold) begin
      wr_en = wr; rd_en = rd; address = addr; write_data = wd;
    end else begin
      wr_en = 1'b0; rd_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b0; address = '0; write_data = '0;
    repeat (2) @(negedge clk);
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_held: got %b want 1", ready);
    end
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (debug_state !== IDLE || ready !== 1'b1 || sram_we_n !== 1'b1 ||
        sram_dq_oe !== 1'b0 || sram_addr !== 18'd0 || read_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: st=%0d rdy=%b we_n=%b oe=%b addr=%h rd=%h want 0/1/1/0/0/0",
               debug_state, ready, sram_we_n, sram_dq_oe, sram_addr, read_data);
    end
  endtask

  task automatic test_write();
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
    total++;
    if ({sram_mem[1], sram_mem[0]} !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL write_mem: got %h want deadbeef", {sram_mem[1], sram_mem[0]});
    end
  endtask

  task automatic test_read();
    access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
    total++;
    if (read_data !== 32'h12345678) begin
      bad++;
      $display("FAIL read_value: got %h want 12345678", read_data);
    end
  endtask

  task automatic test_conflict();
    access(1'b1, 1'b1, 32'd1040, $urandom, 1'b0);
    total++;
    if (read_data !== 32'h12345678) begin
      bad++;
      $display("FAIL conflict_read_data: got %h want 12345678", read_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] d;
    a = 32'd1024 + 32'd64;
    d = $urandom;
    access(1'b1, 1'b0, a, d, 1'b1);
    access(1'b1, 1'b0, a, d, 1'b0);
    access(1'b0, 1'b1, a, 32'h0, 1'b1);
    access(1'b0, 1'b1, a, 32'h0, 1'b0);
  endtask

  task automatic test_wrap();
    access(1'b1, 1'b0, 32'd1020, $urandom, 1'b0);
    access(1'b0, 1'b1, 32'd1020, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] addrs [$];
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      addrs.push_back(a);
      access(1'b1, 1'($urandom), a, $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 8; i++) begin
      access(1'b0, 1'b1, addrs[i], 32'h0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1024 + 32'h0004_0000;
    write_data = $urandom;
    repeat (W + 1) @(negedge clk);
    total++;
    if (debug_state !== HIGH) begin
      bad++;
      $display("FAIL reset_mid_pre: state=%0d want %0d", debug_state, HIGH);
    end
    #2 rst = 1'b1;
    #1;
    last_rd = 32'd0;
    total++;
    if (debug_state !== IDLE || ready !== 1'b1 || sram_we_n !== 1'b1 ||
        sram_dq_oe !== 1'b0 || sram_addr !== 18'd0 || read_data !== last_rd) begin
      bad++;
      $display("FAIL reset_mid: st=%0d rdy=%b we_n=%b oe=%b addr=%h rd=%h want 0/1/1/0/0/0",
               debug_state, ready, sram_we_n, sram_dq_oe, sram_addr, read_data);
    end
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    last_rd = 32'd0;
    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
    sram_mem[4] = 16'h5678;
    sram_mem[5] = 16'h1234;
    ref_mem[4] = 16'h5678;
    ref_mem[5] = 16'h1234;
    test_reset();
    test_write();
    test_read();
    test_conflict();
    test_back_to_back();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
